// File: rtl/req_transfer_tx.sv
// Two-phase bundled-data request transmitter: captures one word per handshake,
// toggles req_out after a setup delay and waits for the matching ack level.
module req_transfer_tx #(
  parameter int DATA_W    = 32,
  parameter int SETUP_CYC = 2,
  parameter int TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] data_out,
  output logic              req_out,
  input  logic              ack_in,
  output logic              busy,
  input  logic              err_clr,
  output logic              timeout_err,
  output logic              proto_err,
  output logic [15:0]       tx_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  localparam logic [3:0]  SETUP_LD  = 4'(SETUP_CYC);
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  state_t            state_r, state_s;
  logic [3:0]        setup_cnt_r, setup_cnt_s;
  logic [15:0]       wait_cnt_r, wait_cnt_s;
  logic [2:0]        guard_r;
  logic [DATA_W-1:0] data_r, data_s;
  logic              req_r, req_s;
  logic [15:0]       tx_count_r, tx_count_s;
  logic              timeout_r, timeout_s;
  logic              proto_r, proto_s;
  logic              in_ready_r, busy_r;
  logic              ack_match_s, timeout_set_s, proto_set_s;

  assign ack_match_s = (ack_in == req_r);

  // Next-state, datapath and sticky-error logic
  always_comb begin
    state_s       = state_r;
    setup_cnt_s   = setup_cnt_r;
    wait_cnt_s    = wait_cnt_r;
    data_s        = data_r;
    req_s         = req_r;
    tx_count_s    = tx_count_r;
    timeout_set_s = 1'b0;
    proto_set_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          data_s      = in_data;
          setup_cnt_s = SETUP_LD;
          state_s     = SETUP;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (setup_cnt_r <= 4'd1) begin
          setup_cnt_s = 4'd0;
          req_s       = ~req_r;
          wait_cnt_s  = 16'd0;
          state_s     = WAIT_ACK;
        end else begin
          setup_cnt_s = setup_cnt_r - 4'd1;
        end
      end
      WAIT_ACK: begin
        if (ack_match_s) begin
          tx_count_s = tx_count_r + 16'd1;
          state_s    = IDLE;
        end else begin
          if (wait_cnt_r < TIMEOUT_W) begin
            wait_cnt_s = wait_cnt_r + 16'd1;
          end else begin
            wait_cnt_s = wait_cnt_r;
          end
          timeout_set_s = (wait_cnt_s == TIMEOUT_W);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // An ack mismatch outside WAIT_ACK is a protocol error once the guard has expired
    if ((state_r != WAIT_ACK) && (guard_r == 3'd0) && !ack_match_s) begin
      proto_set_s = 1'b1;
    end else begin
      proto_set_s = 1'b0;
    end

    if (timeout_set_s) begin
      timeout_s = 1'b1;
    end else if (err_clr) begin
      timeout_s = 1'b0;
    end else begin
      timeout_s = timeout_r;
    end

    if (proto_set_s) begin
      proto_s = 1'b1;
    end else if (err_clr) begin
      proto_s = 1'b0;
    end else begin
      proto_s = proto_r;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      setup_cnt_r <= 4'd0;
      wait_cnt_r  <= 16'd0;
      data_r      <= '0;
      req_r       <= 1'b0;
      tx_count_r  <= 16'd0;
      timeout_r   <= 1'b0;
      proto_r     <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      setup_cnt_r <= setup_cnt_s;
      wait_cnt_r  <= wait_cnt_s;
      data_r      <= data_s;
      req_r       <= req_s;
      tx_count_r  <= tx_count_s;
      timeout_r   <= timeout_s;
      proto_r     <= proto_s;
      in_ready_r  <= (state_s == IDLE);
      busy_r      <= (state_s != IDLE);
    end
  end

  // Post-reset guard masks the protocol check while the ack synchronizer flushes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      guard_r <= 3'd4;
    end else if (guard_r != 3'd0) begin
      guard_r <= guard_r - 3'd1;
    end else begin
      guard_r <= guard_r;
    end
  end

  assign in_ready    = in_ready_r;
  assign busy        = busy_r;
  assign data_out    = data_r;
  assign req_out     = req_r;
  assign tx_count    = tx_count_r;
  assign timeout_err = timeout_r;
  assign proto_err   = proto_r;

endmodule
